// File: rtl/dds_phase_gen_if.sv
// Bus bundle between the sampling controller, dds_phase_gen and the DAC stage.
// Phase_Off is present only when DDS_PHASE_OFFSET_EN is defined.
interface dds_phase_gen_if #(
  parameter int PHASE_W = 24,
  parameter int OUT_W   = 12
) ();
  logic               Enable;
  logic               Ready;
  logic [PHASE_W-1:0] Ftw_In;
  logic               Ftw_Load;
  logic [1:0]         Wave_Sel;
  logic [OUT_W-1:0]   Sample;
  logic               Sample_Valid;
  logic               Wrap;
  logic               Ftw_Busy;
`ifdef DDS_PHASE_OFFSET_EN
  logic [PHASE_W-1:0] Phase_Off;

  modport master (
    output Enable, Ready, Ftw_In, Ftw_Load, Wave_Sel, Phase_Off,
    input  Sample, Sample_Valid, Wrap, Ftw_Busy
  );
  modport slave (
    input  Enable, Ready, Ftw_In, Ftw_Load, Wave_Sel, Phase_Off,
    output Sample, Sample_Valid, Wrap, Ftw_Busy
  );
`else
  modport master (
    output Enable, Ready, Ftw_In, Ftw_Load, Wave_Sel,
    input  Sample, Sample_Valid, Wrap, Ftw_Busy
  );
  modport slave (
    input  Enable, Ready, Ftw_In, Ftw_Load, Wave_Sel,
    output Sample, Sample_Valid, Wrap, Ftw_Busy
  );
`endif
endinterface

// File: rtl/dds_phase_gen.sv
// Two-stage DDS phase accumulator with saw/square/triangle/midscale mapping and
// wrap-synchronised FTW updates. Optional phase offset via DDS_PHASE_OFFSET_EN.
module dds_phase_gen #(
  parameter int                 PHASE_W   = 24,
  parameter int                 OUT_W     = 12,
  parameter logic [PHASE_W-1:0] FTW_RESET = 24'h010000
) (
  input logic            Fg_CLK,
  input logic            RESETn,
  dds_phase_gen_if.slave bus
);

  logic               step_s;
  logic [PHASE_W:0]   sum_s;
  logic               carry_s;
  logic [PHASE_W-1:0] map_phase_s;

  logic [PHASE_W-1:0] acc_r;
  logic [PHASE_W-1:0] ftw_active_r;
  logic [PHASE_W-1:0] ftw_pend_r;
  logic               ftw_busy_r;
  logic               s1_valid_r;
  logic               s1_carry_r;
  logic [1:0]         s1_sel_r;
`ifdef DDS_PHASE_OFFSET_EN
  logic [PHASE_W-1:0] s1_off_r;
`endif
  logic [OUT_W-1:0]   sample_r;
  logic               sample_valid_r;
  logic               wrap_r;

  function automatic logic [OUT_W-1:0] map_sample(input logic [1:0] sel,
                                                  input logic [PHASE_W-1:0] ph);
    logic [OUT_W-1:0] tri_s;
    tri_s = ph[PHASE_W-2 -: OUT_W];
    case (sel)
      2'd0:    map_sample = ph[PHASE_W-1 -: OUT_W];
      2'd1:    map_sample = ph[PHASE_W-1] ? {OUT_W{1'b0}} : {OUT_W{1'b1}};
      2'd2:    map_sample = ph[PHASE_W-1] ? ~tri_s : tri_s;
      2'd3:    map_sample = {1'b1, {(OUT_W-1){1'b0}}};
      default: map_sample = {OUT_W{1'b0}};
    endcase
  endfunction

  // Step qualification, accumulator sum with carry, and stage-2 phase select.
  always_comb begin
    step_s  = bus.Enable && bus.Ready;
    sum_s   = {1'b0, acc_r} + {1'b0, ftw_active_r};
    carry_s = sum_s[PHASE_W];
`ifdef DDS_PHASE_OFFSET_EN
    map_phase_s = acc_r + s1_off_r;
`else
    map_phase_s = acc_r;
`endif
  end

  // Stage 1: accumulator advance; wave select and offset ride along with the step.
  always_ff @(posedge Fg_CLK) begin
    if (!RESETn) begin
      acc_r      <= {PHASE_W{1'b0}};
      s1_valid_r <= 1'b0;
      s1_carry_r <= 1'b0;
      s1_sel_r   <= 2'd0;
`ifdef DDS_PHASE_OFFSET_EN
      s1_off_r   <= {PHASE_W{1'b0}};
`endif
    end else begin
      s1_valid_r <= step_s;
      s1_carry_r <= step_s && carry_s;
      if (step_s) begin
        acc_r    <= sum_s[PHASE_W-1:0];
        s1_sel_r <= bus.Wave_Sel;
`ifdef DDS_PHASE_OFFSET_EN
        s1_off_r <= bus.Phase_Off;
`endif
      end
    end
  end

  // FTW queue: a new word only takes effect after the step that wraps the phase.
  always_ff @(posedge Fg_CLK) begin
    if (!RESETn) begin
      ftw_active_r <= FTW_RESET;
      ftw_pend_r   <= {PHASE_W{1'b0}};
      ftw_busy_r   <= 1'b0;
    end else if (step_s && carry_s) begin
      if (bus.Ftw_Load) begin
        ftw_active_r <= bus.Ftw_In;
        ftw_busy_r   <= 1'b0;
      end else if (ftw_busy_r) begin
        ftw_active_r <= ftw_pend_r;
        ftw_busy_r   <= 1'b0;
      end
    end else if (bus.Ftw_Load) begin
      ftw_pend_r <= bus.Ftw_In;
      ftw_busy_r <= 1'b1;
    end
  end

  // Stage 2: waveform mapping and output strobes.
  always_ff @(posedge Fg_CLK) begin
    if (!RESETn) begin
      sample_r       <= {OUT_W{1'b0}};
      sample_valid_r <= 1'b0;
      wrap_r         <= 1'b0;
    end else if (s1_valid_r) begin
      sample_r       <= map_sample(s1_sel_r, map_phase_s);
      sample_valid_r <= 1'b1;
      wrap_r         <= s1_carry_r;
    end else begin
      sample_valid_r <= 1'b0;
      wrap_r         <= 1'b0;
    end
  end

  assign bus.Sample       = sample_r;
  assign bus.Sample_Valid = sample_valid_r;
  assign bus.Wrap         = wrap_r;
  assign bus.Ftw_Busy     = ftw_busy_r;

endmodule
